// File: rtl/redstone_pkg.sv
// Shared definitions for the comparator-based redstone strength link.
// Used by the frame transmitter and, later, by the matching receiver.
package redstone_pkg;

    typedef logic [3:0] redstone_t;

    localparam redstone_t SS_IDLE         = 4'd0;
    localparam redstone_t SS_START        = 4'd15;
    localparam redstone_t SS_DIGIT_OFFSET = 4'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DIGIT = 2'd2,
        CHECK = 2'd3
    } tx_state_t;

    // Octal digit 0..7 maps to strength 1..8 so a digit never reads as a gap.
    function automatic redstone_t digit_level(input logic [2:0] digit);
        return redstone_t'({1'b0, digit}) + SS_DIGIT_OFFSET;
    endfunction

endpackage

// File: rtl/ss_symbol_timer.sv
// Per-symbol tick timer: HOLD ticks of level followed by GAP ticks of zero.
// Down-counts from HOLD+GAP-1 to 0; terminal count marks the last gap tick.
module ss_symbol_timer #(
    parameter int HOLD = 2,
    parameter int GAP  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic phase_hold,
    output logic sym_end
);

    localparam int LEN = HOLD + GAP;
    localparam int CW  = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST  = CW'(LEN - 1);
    localparam logic [CW-1:0] GAP_C = CW'(GAP);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clear || !enable || (cnt_q == '0)) begin
            cnt_d = LAST;
        end
    end

    // phase_hold describes the tick about to start, so the owner can register
    // its line level in the same edge the count advances.
    assign phase_hold = (cnt_d >= GAP_C);
    assign sym_end    = enable && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ss_frame_tx.sv
// Signal-strength frame transmitter: start mark, octal digits MSB first,
// then a mod-8 checksum level, each held HOLD ticks and followed by GAP zeros.
//
// state | meaning
// IDLE  | line at 0, in_ready high, waiting for a word
// START | driving the start mark (15)
// DIGIT | driving octal digit digit_q of the latched word (1..8)
// CHECK | driving the checksum level, then pulse done
module ss_frame_tx
    import redstone_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       ss_out,
    output logic             busy,
    output logic             done
);

    localparam int DIGITS = WIDTH / 3;
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

    tx_state_t        state_q, state_d;
    logic [DW-1:0]    digit_q, digit_d;
    logic [WIDTH-1:0] data_q, data_d;
    redstone_t        ss_out_q, ss_out_d;
    logic             in_ready_q, in_ready_d;
    logic             done_q, done_d;

    logic       accept;
    logic       phase_hold;
    logic       sym_end;
    logic [2:0] checksum;
    logic [2:0] sel_digit;
    redstone_t  level_d;

    assign accept = in_valid && in_ready_q;

    ss_symbol_timer #(
        .HOLD (HOLD),
        .GAP  (GAP)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .enable     (state_q != IDLE),
        .phase_hold (phase_hold),
        .sym_end    (sym_end)
    );

    always_comb begin
        checksum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            checksum = checksum + data_q[3*i +: 3];
        end
    end

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    data_d  = in_data;
                    digit_d = '0;
                end
            end
            START: begin
                if (sym_end) begin
                    state_d = DIGIT;
                    digit_d = '0;
                end
            end
            DIGIT: begin
                if (sym_end) begin
                    if (digit_q == LAST_DIGIT) begin
                        state_d = CHECK;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (sym_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit 0 is the most significant octal digit of the word.
    always_comb begin
        sel_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_d == DW'(i)) begin
                sel_digit = data_q[WIDTH-1-3*i -: 3];
            end
        end
    end

    always_comb begin
        case (state_d)
            START:   level_d = SS_START;
            DIGIT:   level_d = digit_level(sel_digit);
            CHECK:   level_d = digit_level(checksum);
            default: level_d = SS_IDLE;
        endcase
        ss_out_d   = ((state_d != IDLE) && phase_hold) ? level_d : SS_IDLE;
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            digit_q    <= '0;
            data_q     <= '0;
            ss_out_q   <= SS_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            data_q     <= data_d;
            ss_out_q   <= ss_out_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = ~in_ready_q;
    assign ss_out   = ss_out_q;
    assign done     = done_q;

endmodule
